// File: rtl/obstacle_pkg.sv
// Shared types and the per-level obstacle layout ROM for the snake-game obstacle table.
package obstacle_pkg;

  localparam int CELL_W = 20;
  localparam int CELL_H = 16;

  typedef enum logic [1:0] {READY, LOAD, CHECK, DONE} state_e;

  typedef struct packed {
    logic       valid;
    logic [9:0] ox;
    logic [9:0] oy;
  } obs_entry_t;

  // Layouts: 1 = two horizontal bars, 2 = two vertical bars, 3 = upper bar only.
  function automatic obs_entry_t level_rom(input logic [1:0] level, input logic [4:0] idx);
    obs_entry_t e;
    logic [9:0] i3;
    e  = '0;
    i3 = {7'd0, idx[2:0]};
    case (level)
      2'd1: if (idx < 5'd16) begin
        e.valid = 1'b1;
        e.ox    = 10'd221 + 10'd20 * i3;
        e.oy    = idx[3] ? 10'd305 : 10'd81;
      end
      2'd2: if (idx < 5'd16) begin
        e.valid = 1'b1;
        e.ox    = idx[3] ? 10'd481 : 10'd141;
        e.oy    = 10'd113 + 10'd16 * i3;
      end
      2'd3: if (idx < 5'd8) begin
        e.valid = 1'b1;
        e.ox    = 10'd221 + 10'd20 * i3;
        e.oy    = 10'd81;
      end
      default: ;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/obstacle_level_ctrl_hit.sv
// Combinational single-cell hit compare; bounds are widened to 11 bits so ox+CELL_W never wraps.
module obs_rect_hit #(
  parameter int CELL_W = obstacle_pkg::CELL_W,
  parameter int CELL_H = obstacle_pkg::CELL_H
) (
  input  logic       valid_i,
  input  logic [9:0] ox_i,
  input  logic [9:0] oy_i,
  input  logic [9:0] px_i,
  input  logic [9:0] py_i,
  output logic       hit_o
);

  logic [10:0] x_end, y_end;

  assign x_end = {1'b0, ox_i} + 11'(CELL_W);
  assign y_end = {1'b0, oy_i} + 11'(CELL_H);
  assign hit_o = valid_i && (px_i >= ox_i) && ({1'b0, px_i} < x_end)
                         && (py_i >= oy_i) && ({1'b0, py_i} < y_end);

endmodule

// File: rtl/obstacle_level_ctrl.sv
// Obstacle table owner: ROM-driven level load, sequential collision scan, pixel flag.
// Optional border wall (extra scan cycle, border band in pixel flag) under OBS_WALL_EN.
module obstacle_level_ctrl
  import obstacle_pkg::*;
#(
  parameter int NUM_OBS    = 16,
  parameter int CELL_W     = obstacle_pkg::CELL_W,
  parameter int CELL_H     = obstacle_pkg::CELL_H,
  parameter int NUM_LEVELS = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       en_i,
  input  logic [1:0] level_sel_i,
  input  logic       level_load_i,
  input  logic       check_req_i,
  input  logic [9:0] head_x_i,
  input  logic [9:0] head_y_i,
  input  logic       crash_clr_i,
  input  logic [9:0] pixel_x_i,
  input  logic [9:0] pixel_y_i,
  output logic       busy_o,
  output logic       check_done_o,
  output logic       check_hit_o,
  output logic       crashed_o,
  output logic [1:0] level_cur_o,
  output logic       obstacle_region_o
);

  localparam int             IDX_W = $clog2(NUM_OBS);
  localparam logic [IDX_W-1:0] LAST  = IDX_W'(NUM_OBS - 1);

  state_e                   state_q, state_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [1:0]               sel_q, sel_d, lvl_q, lvl_d, sel_in;
  logic                     pend_q, pend_d, hit_q, hit_d, crashed_q, crashed_d;
  logic [9:0]               hx_q, hx_d, hy_q, hy_d;
  logic                     region_q, region_d;
  obs_entry_t [NUM_OBS-1:0] tbl_q;
  obs_entry_t               scan_e, rom_e;
  logic                     scan_hit, scan_stop;
  logic [NUM_OBS-1:0]       pix_hit;

  // Out-of-range level selects fall back to the empty layout.
  assign sel_in = (int'(level_sel_i) < NUM_LEVELS) ? level_sel_i : 2'd0;
  assign scan_e = tbl_q[idx_q];
  assign rom_e  = level_rom(sel_q, 5'(idx_q));

  obs_rect_hit #(.CELL_W(CELL_W), .CELL_H(CELL_H)) u_scan (
    .valid_i(scan_e.valid), .ox_i(scan_e.ox), .oy_i(scan_e.oy),
    .px_i(hx_q), .py_i(hy_q), .hit_o(scan_hit)
  );

  for (genvar g = 0; g < NUM_OBS; g++) begin : g_pix
    obs_rect_hit #(.CELL_W(CELL_W), .CELL_H(CELL_H)) u_pix (
      .valid_i(tbl_q[g].valid), .ox_i(tbl_q[g].ox), .oy_i(tbl_q[g].oy),
      .px_i(pixel_x_i), .py_i(pixel_y_i), .hit_o(pix_hit[g])
    );
  end

`ifdef OBS_WALL_EN
  logic wall_q, wall_d, wall_hit_q, wall_hit_d;

  function automatic logic border(input logic [9:0] x, input logic [9:0] y);
    return (x < 10'd20) || (x >= 10'd620) || (y < 10'd16) || (y >= 10'd464);
  endfunction

  // The border result is registered so it joins the entry-0 compare one cycle later.
  assign scan_stop = !wall_q && (scan_hit || wall_hit_q);
  assign region_d  = en_i && (state_q != LOAD) && ((|pix_hit) || border(pixel_x_i, pixel_y_i));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wall_q     <= 1'b0;
      wall_hit_q <= 1'b0;
    end else begin
      wall_q     <= wall_d;
      wall_hit_q <= wall_hit_d;
    end
  end

  always_comb begin
    wall_d     = 1'b0;
    wall_hit_d = wall_hit_q;
    if (state_q == READY && !level_load_i && check_req_i) begin
      wall_d     = 1'b1;
      wall_hit_d = 1'b0;
    end else if (state_q == CHECK && wall_q) begin
      wall_hit_d = border(hx_q, hy_q);
    end
  end
`else
  logic wall_q;
  assign wall_q    = 1'b0;
  assign scan_stop = scan_hit;
  assign region_d  = en_i && (state_q != LOAD) && (|pix_hit);
`endif

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    sel_d     = sel_q;
    pend_d    = pend_q;
    hx_d      = hx_q;
    hy_d      = hy_q;
    hit_d     = hit_q;
    lvl_d     = lvl_q;
    crashed_d = crash_clr_i ? 1'b0 : crashed_q;
    case (state_q)
      READY: begin
        if (level_load_i) begin
          state_d = LOAD;
          idx_d   = '0;
          sel_d   = sel_in;
        end else if (check_req_i) begin
          state_d = CHECK;
          idx_d   = '0;
          hx_d    = head_x_i;
          hy_d    = head_y_i;
        end
      end
      LOAD: begin
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST) begin
          lvl_d     = sel_q;
          crashed_d = 1'b0;
          idx_d     = '0;
          state_d   = READY;
        end
      end
      CHECK: begin
        if (level_load_i) begin
          pend_d = 1'b1;
          sel_d  = sel_in;
        end
        if (!wall_q) begin
          if (scan_stop || idx_q == LAST) begin
            hit_d   = scan_stop;
            state_d = DONE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      DONE: begin
        if (hit_q) crashed_d = 1'b1;
        idx_d = '0;
        if (pend_q) begin
          pend_d  = 1'b0;
          state_d = LOAD;
        end else begin
          state_d = READY;
        end
      end
      default: state_d = READY;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= READY;
      idx_q     <= '0;
      sel_q     <= '0;
      pend_q    <= 1'b0;
      hx_q      <= '0;
      hy_q      <= '0;
      hit_q     <= 1'b0;
      crashed_q <= 1'b0;
      lvl_q     <= '0;
      region_q  <= 1'b0;
      tbl_q     <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      sel_q     <= sel_d;
      pend_q    <= pend_d;
      hx_q      <= hx_d;
      hy_q      <= hy_d;
      hit_q     <= hit_d;
      crashed_q <= crashed_d;
      lvl_q     <= lvl_d;
      region_q  <= region_d;
      if (state_q == LOAD) tbl_q[idx_q] <= rom_e;
    end
  end

  assign busy_o            = (state_q == LOAD) || (state_q == CHECK);
  assign check_done_o      = (state_q == DONE);
  assign check_hit_o       = hit_q;
  assign crashed_o         = crashed_q;
  assign level_cur_o       = lvl_q;
  assign obstacle_region_o = region_q;

endmodule

// File: tb/tb_obstacle_level_ctrl.sv
// Directed self-checking bench for obstacle_level_ctrl (OBS_WALL_EN adds one scan cycle).
module tb_obstacle_level_ctrl;

`ifdef OBS_WALL_EN
  localparam int W = 1;
`else
  localparam int W = 0;
`endif

  logic       clk, rst_n, en, level_load, check_req, crash_clr;
  logic [1:0] level_sel;
  logic [9:0] head_x, head_y, pixel_x, pixel_y;
  logic       busy, check_done, check_hit, crashed, obstacle_region;
  logic [1:0] level_cur;

  int nchk = 0;
  int nerr = 0;

  obstacle_level_ctrl dut (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .level_sel_i(level_sel),
    .level_load_i(level_load), .check_req_i(check_req),
    .head_x_i(head_x), .head_y_i(head_y), .crash_clr_i(crash_clr),
    .pixel_x_i(pixel_x), .pixel_y_i(pixel_y), .busy_o(busy),
    .check_done_o(check_done), .check_hit_o(check_hit), .crashed_o(crashed),
    .level_cur_o(level_cur), .obstacle_region_o(obstacle_region)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Pulse level_load and count busy cycles until the load completes.
  task automatic load_level(input logic [1:0] sel, input int exp_lvl);
    int n;
    level_sel = sel; level_load = 1'b1;
    @(negedge clk);
    level_load = 1'b0;
    n = 0;
    while (busy && n < 40) begin n++; @(negedge clk); end
    chk("load_busy_cycles", n, 16);
    chk("level_cur", int'(level_cur), exp_lvl);
  endtask

  // Issue a query; returns cycles from request to check_done (40 = timeout).
  task automatic query(input int hx, input int hy, output int lat);
    head_x = 10'(hx); head_y = 10'(hy); check_req = 1'b1;
    @(negedge clk);
    check_req = 1'b0;
    lat = 1;
    while (!check_done && lat < 40) begin lat++; @(negedge clk); end
  endtask

  task automatic pix(input int x, input int y, input int exp, input string tag);
    pixel_x = 10'(x); pixel_y = 10'(y);
    @(negedge clk);
    chk(tag, int'(obstacle_region), exp);
  endtask

  initial begin
    int lat, n, dones;
    rst_n = 1'b0; en = 1'b0; level_sel = '0; level_load = 1'b0; check_req = 1'b0;
    crash_clr = 1'b0; head_x = '0; head_y = '0; pixel_x = '0; pixel_y = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(check_done), 0);
    chk("rst_hit", int'(check_hit), 0);
    chk("rst_crashed", int'(crashed), 0);
    chk("rst_level", int'(level_cur), 0);
    chk("rst_region", int'(obstacle_region), 0);
    rst_n = 1'b1;
    @(negedge clk);

    load_level(2'd1, 1);
    en = 1'b1;
    pix(225, 85, 1, "pix_225_85");
    pix(220, 85, 0, "pix_220_85");
    pix(380, 320, 1, "pix_380_320");
    pix(381, 320, 0, "pix_381_320");
    en = 1'b0;
    pix(225, 85, 0, "pix_en_off");
    en = 1'b1;

    // Hit at entry 4 with crash_clr held: the set in DONE must win.
    crash_clr = 1'b1;
    query(301, 81, lat);
    chk("hit4_latency", lat, 6 + W);
    chk("hit4_hit", int'(check_hit), 1);
    @(negedge clk);
    crash_clr = 1'b0;
    chk("hit4_crashed", int'(crashed), 1);
    crash_clr = 1'b1;
    @(negedge clk);
    crash_clr = 1'b0;
    chk("crash_clr", int'(crashed), 0);

    query(240, 96, lat);
    chk("edge_hit0_latency", lat, 2 + W);
    chk("edge_hit0_hit", int'(check_hit), 1);
    @(negedge clk);
    crash_clr = 1'b1;
    @(negedge clk);
    crash_clr = 1'b0;

    query(200, 200, lat);
    chk("miss_latency", lat, 17 + W);
    chk("miss_hit", int'(check_hit), 0);
    @(negedge clk);
    chk("miss_crashed", int'(crashed), 0);

    // Load and query in the same READY cycle: load wins, query is dropped.
    level_sel = 2'd3; level_load = 1'b1; check_req = 1'b1;
    head_x = 10'd225; head_y = 10'd85;
    @(negedge clk);
    level_load = 1'b0; check_req = 1'b0;
    n = 0; dones = 0;
    for (int i = 0; i < 30; i++) begin
      if (busy) n++;
      if (check_done) dones++;
      @(negedge clk);
    end
    chk("collide_busy", n, 16);
    chk("collide_no_done", dones, 0);
    chk("collide_level", int'(level_cur), 3);
    pix(225, 305, 0, "lvl3_lower_gone");
    pix(225, 85, 1, "lvl3_upper");

    // Load requested mid-query: query completes, then LOAD starts at once.
    head_x = 10'd200; head_y = 10'd200; check_req = 1'b1;
    @(negedge clk);
    check_req = 1'b0;
    lat = 1;
    while (!check_done && lat < 40) begin
      if (lat == 3) begin level_sel = 2'd0; level_load = 1'b1; end
      else level_load = 1'b0;
      lat++;
      @(negedge clk);
    end
    level_load = 1'b0;
    chk("pend_latency", lat, 17 + W);
    chk("pend_hit", int'(check_hit), 0);
    @(negedge clk);
    n = 0;
    while (busy && n < 40) begin n++; @(negedge clk); end
    chk("pend_load_busy", n, 16);
    chk("pend_level", int'(level_cur), 0);
    pix(225, 85, 0, "lvl0_pix_a");
    pix(380, 320, 0, "lvl0_pix_b");

    // Reset pulsed mid-scan while entry 5 is compared.
    load_level(2'd1, 1);
    head_x = 10'd200; head_y = 10'd200; check_req = 1'b1;
    @(negedge clk);
    check_req = 1'b0;
    repeat (5 + W) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_level", int'(level_cur), 0);
    chk("midrst_done", int'(check_done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 25; i++) begin
      if (check_done) dones++;
      @(negedge clk);
    end
    chk("midrst_no_done", dones, 0);
    query(225, 85, lat);
    chk("midrst_inval_latency", lat, 17 + W);
    chk("midrst_inval_hit", int'(check_hit), 0);
    @(negedge clk);

`ifdef OBS_WALL_EN
    query(5, 200, lat);
    chk("wall_latency", lat, 3);
    chk("wall_hit", int'(check_hit), 1);
    @(negedge clk);
`endif

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
